lc3_seq_core: RTL and testbench

- Parametrised, self-sequencing LC-3 core; successor to the externally-controlled LC-3 datapath top.
- Integrates register file, ALU, NZP, PC, IR and MAR with an internal multi-cycle control FSM.
- Talks to external memory over a req/ready handshake instead of embedding memory.
- Sits under the system top; memory and bus fabric attach to its mem_* ports.

---
 rtl/lc3_pkg.sv | 32 +++
 rtl/lc3_regfile.sv | 31 +++
 rtl/lc3_seq_core.sv | 184 ++++++++++++++++++
 tb/tb_lc3_seq_core.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared opcode, trap, FSM-state and condition-code definitions for the sequenced LC-3 core.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [7:0] TRAP_HALT = 8'h25;

  typedef logic [2:0] stateT;
  localparam stateT S_IDLE   = 3'd0;
  localparam stateT S_FETCH  = 3'd1;
  localparam stateT S_DECODE = 3'd2;
  localparam stateT S_EXEC   = 3'd3;
  localparam stateT S_MEM    = 3'd4;
  localparam stateT S_HALT   = 3'd5;

  // {N,Z,P}
  typedef logic [2:0] nzpT;
  localparam nzpT NZP_RESET = 3'b010;

  localparam int unsigned NUM_REGS = 8;

endpackage

// File: rtl/lc3_regfile.sv
// Eight-entry register file: two asynchronous read ports, one synchronous write port.
module lc3_regfile
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddrA,
  input  logic [2:0]        raddrB,
  output logic [DATA_W-1:0] rdataA,
  output logic [DATA_W-1:0] rdataB
);

  logic [DATA_W-1:0] regsQ [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regsQ[i] <= '0;
    end else if (we) begin
      regsQ[waddr] <= wdata;
    end
  end

  assign rdataA = regsQ[raddrA];
  assign rdataB = regsQ[raddrB];

endmodule

// File: rtl/lc3_seq_core.sv
// Self-sequencing multi-cycle LC-3 core with a req/ready memory port.
// Optional LC3_PERF_CNT_EN adds saturating retired / stall_cycles counters.
module lc3_seq_core
  import lc3_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h3000)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_out,
  output logic [2:0]        nzp_out
`ifdef LC3_PERF_CNT_EN
  ,
  output logic [31:0]       retired,
  output logic [31:0]       stall_cycles
`endif
);

  stateT             stateQ, stateD;
  logic [ADDR_W-1:0] pcQ, pcD, marQ, marD;
  logic [15:0]       irQ, irD;
  nzpT               nzpQ, nzpD;
  logic              illegalQ, illegalD;

  logic              rfWe;
  logic [DATA_W-1:0] rfWdata, rdA, rdB, aluB, aluRes;
  logic [DATA_W-1:0] imm5, off6, off9;
  logic [ADDR_W-1:0] pcOff, baseOff;
  logic [3:0]        opcode;
  logic              isStore, brTaken;

  function automatic nzpT calcNzp(input logic [DATA_W-1:0] v);
    if (v[DATA_W-1])  return 3'b100;
    else if (v == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  assign opcode  = irQ[15:12];
  assign isStore = (opcode == OP_ST) || (opcode == OP_STR);
  assign imm5    = {{(DATA_W-5){irQ[4]}}, irQ[4:0]};
  assign off6    = {{(DATA_W-6){irQ[5]}}, irQ[5:0]};
  assign off9    = {{(DATA_W-9){irQ[8]}}, irQ[8:0]};
  assign pcOff   = pcQ + ADDR_W'(off9);
  assign baseOff = ADDR_W'(rdA + off6);
  assign brTaken = (irQ[11] & nzpQ[2]) | (irQ[10] & nzpQ[1]) | (irQ[9] & nzpQ[0]);

  // Port B doubles as the store-source read; stores never need SR2.
  lc3_regfile #(.DATA_W(DATA_W)) uRegfile (
    .clk    (clk),
    .reset  (reset),
    .we     (rfWe),
    .waddr  (irQ[11:9]),
    .wdata  (rfWdata),
    .raddrA (irQ[8:6]),
    .raddrB (isStore ? irQ[11:9] : irQ[2:0]),
    .rdataA (rdA),
    .rdataB (rdB)
  );

  assign aluB = irQ[5] ? imm5 : rdB;

  always_comb begin
    aluRes = rdA + aluB;
    if (opcode == OP_AND)      aluRes = rdA & aluB;
    else if (opcode == OP_NOT) aluRes = ~rdA;
  end

  always_comb begin
    stateD   = stateQ;
    pcD      = pcQ;
    irD      = irQ;
    marD     = marQ;
    nzpD     = nzpQ;
    illegalD = illegalQ;
    rfWe     = 1'b0;
    rfWdata  = aluRes;
    case (stateQ)
      S_IDLE:   stateD = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          irD    = mem_rdata[15:0];
          pcD    = pcQ + ADDR_W'(1);
          stateD = S_DECODE;
        end
      end
      S_DECODE: stateD = S_EXEC;
      S_EXEC: begin
        stateD = S_FETCH;
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            rfWe = 1'b1;
            nzpD = calcNzp(aluRes);
          end
          OP_BR:  if (brTaken) pcD = pcOff;
          OP_JMP: pcD = ADDR_W'(rdA);
          OP_LEA: begin
            rfWdata = DATA_W'(pcOff);
            rfWe    = 1'b1;
            nzpD    = calcNzp(DATA_W'(pcOff));
          end
          OP_LD, OP_ST: begin
            marD   = pcOff;
            stateD = S_MEM;
          end
          OP_LDR, OP_STR: begin
            marD   = baseOff;
            stateD = S_MEM;
          end
          OP_TRAP: begin
            if (irQ[7:0] == TRAP_HALT) stateD = S_HALT;
            else                       illegalD = 1'b1;
          end
          default: illegalD = 1'b1;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (!isStore) begin
            rfWdata = mem_rdata;
            rfWe    = 1'b1;
            nzpD    = calcNzp(mem_rdata);
          end
          stateD = S_FETCH;
        end
      end
      S_HALT:   stateD = S_HALT;
      default:  stateD = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= S_IDLE;
      pcQ      <= RESET_PC;
      irQ      <= '0;
      marQ     <= '0;
      nzpQ     <= NZP_RESET;
      illegalQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      pcQ      <= pcD;
      irQ      <= irD;
      marQ     <= marD;
      nzpQ     <= nzpD;
      illegalQ <= illegalD;
    end
  end

  // Outputs decode from registered state only, so they hold through wait states.
  assign mem_req   = (stateQ == S_FETCH) || (stateQ == S_MEM);
  assign mem_we    = (stateQ == S_MEM) && isStore;
  assign mem_addr  = (stateQ == S_MEM) ? marQ : pcQ;
  assign mem_wdata = rdB;
  assign halted    = (stateQ == S_HALT);
  assign illegal   = illegalQ;
  assign pc_out    = pcQ;
  assign nzp_out   = nzpQ;

`ifdef LC3_PERF_CNT_EN
  logic retire;
  assign retire = ((stateQ == S_EXEC) && (stateD != S_MEM)) || ((stateQ == S_MEM) && mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else begin
      if (retire && (retired != '1)) retired <= retired + 32'd1;
      if (mem_req && !mem_ready && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lc3_seq_core.sv
// Directed program bench for lc3_seq_core against a behavioural memory with selectable wait states.
module tb_lc3_seq_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        halted, illegal;
  logic [15:0] pc_out;
  logic [2:0]  nzp_out;
`ifdef LC3_PERF_CNT_EN
  logic [31:0] retired, stall_cycles;
`endif

  lc3_seq_core dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .illegal   (illegal),
    .pc_out    (pc_out),
    .nzp_out   (nzp_out)
`ifdef LC3_PERF_CNT_EN
    ,
    .retired      (retired),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  logic        readyEn;
  logic [15:0] slowAddr;
  int          waitCnt = 0;
  int          cycle = 0;
  logic [15:0] wrAddr [0:7];
  logic [15:0] wrData [0:7];
  logic [3:0]  wrCnt = 4'd0;
  int          nCompared = 0;
  int          nMismatched = 0;

  // Only requests to slowAddr see two wait states; all others complete at once.
  assign mem_ready = readyEn && ((mem_addr != slowAddr) || (waitCnt >= 2));
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (!mem_req || mem_ready) waitCnt <= 0;
    else                       waitCnt <= waitCnt + 1;
    if (mem_req && mem_ready && mem_we && (wrCnt < 4'd8)) begin
      wrAddr[wrCnt[2:0]] <= mem_addr;
      wrData[wrCnt[2:0]] <= mem_wdata;
      wrCnt <= wrCnt + 4'd1;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the first sampled cycle of a request to address a.
  task automatic waitReq(input logic [15:0] a, output int cyc);
    logic found;
    found = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_req && (mem_addr == a)) begin
        found = 1'b1;
        cyc   = cycle;
        break;
      end
    end
    checkVal($sformatf("reach_%h", a), {31'd0, found}, 32'd1);
  endtask

  int c0, c1, c2, c3, c4, c6, c7, cb, ca, cc, cd, cj, ck, rel;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h3000] = 16'h5020;  // AND R0,R0,#0
    mem[16'h3001] = 16'h103F;  // ADD R0,R0,#-1
    mem[16'h3002] = 16'h2202;  // LD  R1,x3005
    mem[16'h3003] = 16'h241C;  // LD  R2,x3020
    mem[16'h3004] = 16'h0E01;  // BRnzp x3006
    mem[16'h3006] = 16'h72BF;  // STR R1,R2,#-1
    mem[16'h3007] = 16'h7080;  // STR R0,R2,#0
    mem[16'h3008] = 16'h56E0;  // AND R3,R3,#0
    mem[16'h3009] = 16'h0E01;  // BRnzp x300B
    mem[16'h300A] = 16'h16E1;  // ADD R3,R3,#1
    mem[16'h300B] = 16'h05FE;  // BRz x300A
    mem[16'h300C] = 16'h0805;  // BRn +5 (not taken)
    mem[16'h300D] = 16'h7681;  // STR R3,R2,#1
    mem[16'h300E] = 16'hD000;  // reserved opcode
    mem[16'h300F] = 16'h983F;  // NOT R4,R0
    mem[16'h3010] = 16'hEBF0;  // LEA R5,#-16
    mem[16'h3011] = 16'h7A82;  // STR R5,R2,#2
    mem[16'h3012] = 16'hEC02;  // LEA R6,x3015
    mem[16'h3013] = 16'hC180;  // JMP R6
    mem[16'h3014] = 16'hF025;  // halt if JMP falls through
    mem[16'h3015] = 16'h7C83;  // STR R6,R2,#3
    mem[16'h3016] = 16'hF025;  // TRAP x25
    mem[16'h3020] = 16'h4000;

    reset    = 1'b1;
    readyEn  = 1'b1;
    slowAddr = 16'h3005;
    repeat (3) @(negedge clk);
    checkVal("rst_req", {31'd0, mem_req}, 32'd0);
    checkVal("rst_pc", {16'd0, pc_out}, 32'h3000);
    checkVal("rst_nzp", {29'd0, nzp_out}, 32'd2);
    checkVal("rst_halted", {31'd0, halted}, 32'd0);
    checkVal("rst_illegal", {31'd0, illegal}, 32'd0);

    reset = 1'b0;
    rel   = cycle;
    waitReq(16'h3000, c0);
    checkVal("first_fetch_lat", c0 - rel, 32'd1);
    checkVal("first_fetch_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    checkVal("pc_after_fetch", {16'd0, pc_out}, 32'h3001);

    waitReq(16'h3001, c1);
    checkVal("lat_and", c1 - c0, 32'd3);
    waitReq(16'h3002, c2);
    checkVal("lat_add", c2 - c1, 32'd3);
    checkVal("nzp_add", {29'd0, nzp_out}, 32'b100);

    waitReq(16'h3005, c3);
    @(negedge clk);
    checkVal("ld_wait_req", {31'd0, mem_req}, 32'd1);
    checkVal("ld_wait_addr", {16'd0, mem_addr}, 32'h3005);
    checkVal("ld_wait_we", {31'd0, mem_we}, 32'd0);
    waitReq(16'h3003, c3);
    checkVal("lat_ld_wait", c3 - c2, 32'd6);
    checkVal("nzp_ld_zero", {29'd0, nzp_out}, 32'b010);

    waitReq(16'h3004, c4);
    checkVal("lat_ld", c4 - c3, 32'd4);
    checkVal("nzp_ld_pos", {29'd0, nzp_out}, 32'b001);
    waitReq(16'h3006, c6);
    checkVal("lat_br_taken", c6 - c4, 32'd3);

    waitReq(16'h3FFF, c7);
    checkVal("str_we", {31'd0, mem_we}, 32'd1);
    checkVal("str_wdata", {16'd0, mem_wdata}, 32'h0000);
    waitReq(16'h3007, c7);
    checkVal("lat_str", c7 - c6, 32'd4);
    checkVal("nzp_str_keep", {29'd0, nzp_out}, 32'b001);

    waitReq(16'h300B, cb);
    waitReq(16'h300A, ca);
    checkVal("lat_brz_taken", ca - cb, 32'd3);
    waitReq(16'h300B, cb);
    waitReq(16'h300C, cc);
    checkVal("lat_brz_not", cc - cb, 32'd3);
    waitReq(16'h300D, cd);
    checkVal("lat_brn_not", cd - cc, 32'd3);
    checkVal("illegal_before", {31'd0, illegal}, 32'd0);

    waitReq(16'h300F, cd);
    checkVal("illegal_set", {31'd0, illegal}, 32'd1);
    waitReq(16'h3010, cd);
    checkVal("nzp_not", {29'd0, nzp_out}, 32'b010);
    waitReq(16'h3011, cd);
    checkVal("nzp_lea", {29'd0, nzp_out}, 32'b001);

    waitReq(16'h3013, cj);
    waitReq(16'h3015, ck);
    checkVal("lat_jmp", ck - cj, 32'd3);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    checkVal("halted", {31'd0, halted}, 32'd1);
    checkVal("halt_pc", {16'd0, pc_out}, 32'h3017);
    repeat (3) @(negedge clk);
    checkVal("halt_req", {31'd0, mem_req}, 32'd0);
    checkVal("halt_illegal", {31'd0, illegal}, 32'd1);
`ifdef LC3_PERF_CNT_EN
    checkVal("perf_retired", retired, 32'd22);
    checkVal("perf_stall", stall_cycles, 32'd2);
`endif

    checkVal("wr_count", {28'd0, wrCnt}, 32'd5);
    checkVal("wr0_addr", {16'd0, wrAddr[0]}, 32'h3FFF);
    checkVal("wr0_data", {16'd0, wrData[0]}, 32'h0000);
    checkVal("wr1_addr", {16'd0, wrAddr[1]}, 32'h4000);
    checkVal("wr1_data", {16'd0, wrData[1]}, 32'hFFFF);
    checkVal("wr2_data", {16'd0, wrData[2]}, 32'h0001);
    checkVal("wr3_data", {16'd0, wrData[3]}, 32'h3001);
    checkVal("wr4_addr", {16'd0, wrAddr[4]}, 32'h4003);
    checkVal("wr4_data", {16'd0, wrData[4]}, 32'h3015);

    reset = 1'b1;
    #1;
    checkVal("rst2_halted", {31'd0, halted}, 32'd0);
    checkVal("rst2_illegal", {31'd0, illegal}, 32'd0);
    checkVal("rst2_pc", {16'd0, pc_out}, 32'h3000);
    checkVal("rst2_nzp", {29'd0, nzp_out}, 32'b010);

    readyEn = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    waitReq(16'h3000, c0);
    @(negedge clk);
    checkVal("stall_req", {31'd0, mem_req}, 32'd1);
    checkVal("stall_addr", {16'd0, mem_addr}, 32'h3000);
    #2;
    reset = 1'b1;
    #1;
    checkVal("rst_mid_req", {31'd0, mem_req}, 32'd0);
    checkVal("rst_mid_pc", {16'd0, pc_out}, 32'h3000);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
